riscv_v_wb_stage: RTL

- Vector writeback stage between the vector ALU output (riscv_v_alu_data_t) and the register file write port.
- Buffers ALU results in a small FIFO and converts per-byte valid/merge into the per-byte write enable (riscv_v_rf_wr_en_t).
- Drains one entry per cycle unless the regfile stalls.
- Exposes a pending-write check so issue logic can detect RAW hazards against buffered results.

---
 rtl/riscv_v_pkg.sv | 31 +++
 rtl/riscv_v_wb_fifo.sv | 85 ++++++++
 rtl/riscv_v_wb_stage.sv | 76 +++++++
 3 files changed

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types plus the writeback-stage entry format and helpers.
package riscv_v_pkg;

    localparam int unsigned RISCV_V_VLEN     = 128;
    localparam int unsigned RISCV_V_VLENB    = RISCV_V_VLEN / 8;
    localparam int unsigned RISCV_V_WB_DEPTH = 2;

    typedef logic [RISCV_V_VLEN-1:0]  riscv_v_data_t;
    typedef logic [4:0]               riscv_v_rf_addr_t;
    typedef logic [RISCV_V_VLENB-1:0] riscv_v_rf_wr_en_t;

    // ALU result: data plus per-byte merge (keep old byte) and valid masks
    typedef struct packed {
        riscv_v_data_t     data;
        riscv_v_rf_wr_en_t merge;
        riscv_v_rf_wr_en_t valid;
    } riscv_v_alu_data_t;

    // One buffered register-file write
    typedef struct packed {
        riscv_v_rf_addr_t  addr;
        riscv_v_data_t     data;
        riscv_v_rf_wr_en_t en;
    } riscv_v_wb_entry_t;

    // A byte is written only when it is valid and not merged
    function automatic riscv_v_rf_wr_en_t f_alu_to_wr_en(input riscv_v_alu_data_t a);
        return a.valid & ~a.merge;
    endfunction

endpackage

// File: rtl/riscv_v_wb_fifo.sv
// DEPTH-entry FIFO of writeback entries with flush and per-entry visibility.
module riscv_v_wb_fifo
    import riscv_v_pkg::*;
#(
    parameter int unsigned DEPTH = RISCV_V_WB_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push_i,
    input  logic                                pop_i,
    input  logic                                flush_i,
    input  riscv_v_wb_entry_t                   wr_entry_i,
    output riscv_v_wb_entry_t                   head_o,
    output riscv_v_rf_addr_t  [DEPTH-1:0]       ent_addr_o,
    output riscv_v_rf_wr_en_t [DEPTH-1:0]       ent_en_o,
    output logic              [DEPTH-1:0]       valid_o,
    output logic              [PTR_W:0]         occupancy_o,
    output logic                                full_o,
    output logic                                empty_o
);

    localparam int unsigned CW = PTR_W + 1;

    riscv_v_wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    // Guard the handshakes so the FIFO can never over- or underflow
    always_comb begin
        push_ok  = push_i && !flush_i && (count_q < CW'(DEPTH));
        pop_ok   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_entry_i;
        end
    end

    // Entry i is live when its distance from the head is below the count
    always_comb begin
        valid_o    = '0;
        ent_addr_o = '0;
        ent_en_o   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_o[i]    = {1'b0, PTR_W'(i) - rd_ptr_q} < count_q;
            ent_addr_o[i] = mem_q[i].addr;
            ent_en_o[i]   = mem_q[i].en;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/riscv_v_wb_stage.sv
// Vector writeback stage: buffers ALU results and drives the regfile write port.
module riscv_v_wb_stage
    import riscv_v_pkg::*;
#(
    parameter int unsigned DEPTH = RISCV_V_WB_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  riscv_v_alu_data_t alu_data,
    input  riscv_v_rf_addr_t  alu_dst_addr,
    input  logic              flush,
    input  logic              rf_wr_stall,
    output logic              rf_wr_req,
    output riscv_v_rf_addr_t  rf_wr_addr,
    output riscv_v_rf_wr_en_t rf_wr_en,
    output riscv_v_data_t     rf_wr_data,
    input  riscv_v_rf_addr_t  chk_addr,
    output logic              chk_hit,
    output logic [PTR_W:0]    occupancy,
    output logic              empty
);

    riscv_v_wb_entry_t                 wr_entry;
    riscv_v_wb_entry_t                 head;
    riscv_v_rf_addr_t  [DEPTH-1:0]     ent_addr;
    riscv_v_rf_wr_en_t [DEPTH-1:0]     ent_en;
    logic              [DEPTH-1:0]     ent_valid;
    logic                              full;
    logic                              push;

    // Handshake, byte-enable conversion and stall gating of the head write
    always_comb begin
        alu_ready      = !full && !flush;
        push           = alu_valid && alu_ready;
        wr_entry.addr  = alu_dst_addr;
        wr_entry.data  = alu_data.data;
        wr_entry.en    = f_alu_to_wr_en(alu_data);
        rf_wr_req      = !empty && !rf_wr_stall;
        rf_wr_addr     = head.addr;
        rf_wr_data     = head.data;
        rf_wr_en       = rf_wr_req ? head.en : '0;
    end

    // RAW hazard check against every live entry that writes at least one byte
    always_comb begin
        chk_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == chk_addr) && (ent_en[i] != '0)) begin
                chk_hit = 1'b1;
            end
        end
    end

    riscv_v_wb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (rf_wr_req),
        .flush_i     (flush),
        .wr_entry_i  (wr_entry),
        .head_o      (head),
        .ent_addr_o  (ent_addr),
        .ent_en_o    (ent_en),
        .valid_o     (ent_valid),
        .occupancy_o (occupancy),
        .full_o      (full),
        .empty_o     (empty)
    );

endmodule
